dataflow_op_arbiter: RTL
========================

# dataflow_op_arbiter

Round-robin arbiter sharing one two-operand dataflow operator (AND-class: registered, pulse-in/pulse-out, no backpressure) among CH requester channels. Each channel's operand tokens are latched until both operands are present. The arbiter then issues them to the shared operator, tracks the in-flight channel through a tag pipeline, and steers the result pulse back to the owning channel. It sits between the graph's token producers and a single shared operator instance.

## Interface
- N, 16, operand/result data width
- CH, 4, number of requester channels (2..8)
- OP_LAT, 1, shared operator latency in cycles, issue edge to OP_R_OUT (1..4)
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- EN  in  1  issue enable; captures continue when low
- IN_R1  in  CH  operand-1 token pulse, per channel
- IN_D1  in  CH*N  operand-1 data; channel k at [k*N +: N]
- IN_R2  in  CH  operand-2 token pulse, per channel
- IN_D2  in  CH*N  operand-2 data; same packing as IN_D1
- OP_EN  out  1  shared operator enable
- OP_R_IN1, OP_R_IN2  out  1  issue pulses to the operator
- OP_D_IN1, OP_D_IN2  out  N  issued operands
- OP_R_OUT  in  1  operator result pulse
- OP_D_OUT  in  N  operator result data
- OUT_R  out  CH  result pulse, one-hot, to the owning channel
- OUT_D  out  N  result data, valid while any OUT_R bit is high
- OUT_CH  out  clog2(CH)  index of the channel receiving OUT_D
- BUSY  out  1  any slot full or any tag in flight
- ERR  out  CH  sticky per-channel overflow flag
- ERR_CLR  in  1  clears all ERR bits

## Operation
- Per channel: two operand slots (A, B), each holding N-bit data plus a full flag.
- Capture: at an edge with IN_R1[k]=1, slot A[k] loads IN_D1[k] if it is empty or being issued on that same edge. Slot B uses IN_R2/IN_D2 the same way.
- Overflow: a token arriving at a full slot that is not being issued is dropped. The slot keeps its old data, and ERR[k] sets under the macro.
- Eligible channel: A[k] and B[k] both full.
- Grant: when EN=1, the arbiter searches eligible channels starting at pointer `ptr` and increasing modulo CH. The first hit is granted, and `ptr` then becomes grant+1 mod CH. No eligible channel means no issue and no change to `ptr`.
- Issue (registered): OP_R_IN1=OP_R_IN2=1 for exactly one cycle, with OP_D_IN1/OP_D_IN2 carrying A/B of the granted channel. Both slots of that channel clear on the issue edge.
- Issue rate: at most one issue per cycle. Back-to-back issues are allowed.
- OP_EN: 0 in reset, constant 1 afterwards. EN never gates the operator, because the operator holds R_OUT while its enable is low.
- Tag pipeline: OP_LAT stages of {valid, channel}. Stage 0 loads on each issue and shifts every cycle.
- Result steering: on an edge with OP_R_OUT=1 and the last tag stage valid, the block registers:
  - OUT_R = onehot(tag),
  - OUT_D = OP_D_OUT,
  - OUT_CH = tag.
- Stray result: OP_R_OUT=1 with no valid tag is ignored, and OUT_R stays 0.
- Pulse width: OUT_R is a single-cycle pulse per result.

## Timing
- Reset values: OP_EN, OP_R_IN1, OP_R_IN2, OUT_R, ERR and BUSY are 0. OP_D_IN1, OP_D_IN2, OUT_D, OUT_CH and ptr are 0. All slots are empty and all tags are invalid.
- Latency, uncontended, EN=1: both operands sampled at edge E0, issued at E1, OP_R_OUT at E1+OP_LAT, OUT_R at E2+OP_LAT. With OP_LAT=1 that is 3 cycles.
- Staggered operands: the issue occurs on the edge after the later operand is captured.
- Same-edge capture and issue: the new token is retained in the freed slot, and ERR is not set.
- EN low: no issue. Slots keep filling, and in-flight tags drain normally.
- Reset mid-operation: slots, tags and ptr clear at that edge. In-flight results are discarded, so no OUT_R pulse follows reset.
- ERR_CLR vs new overflow: ERR_CLR takes priority over an overflow on the same edge.
- Throughput: 1 result/cycle at saturation, shared round-robin. With all CH channels eligible, each channel is served once per CH cycles.

## Configuration
- DFARB_ERR_EN defined: overflow detection active, and ERR is a sticky flag cleared by ERR_CLR or RST.
- DFARB_ERR_EN undefined: ERR is tied to 0 and ERR_CLR is ignored. Dropping behaviour on overflow is identical.

## Test plan
- Single token pair: CH=4, OP_LAT=1, channel 2 with IN_D1=0x00FF and IN_D2=0x0F0F at E0 (operator is AND) -> OP_R_IN1/2 pulse at E1, then OUT_R=4'b0100, OUT_D=0x000F, OUT_CH=2 at E3. No other OUT_R pulses.
- All four channels loaded at the same edge, ptr=0 -> issues in order ch0, ch1, ch2, ch3 on consecutive edges, and OUT_CH reads 0,1,2,3 on consecutive cycles. ptr ends at 0.
- Staggered operands: ch1 operand 1 at E0, operand 2 at E3 -> issue at E4, OUT_R[1] at E6.
- Overflow: ch0 gets two IN_R1 pulses with no IN_R2, data 0x1111 then 0x2222 -> ERR[0]=1. A later IN_R2 with 0xFFFF gives OUT_D=0x1111. ERR_CLR then clears ERR[0].
- EN gating and reset: EN=0 with ch3 loaded -> no issue for 10 cycles and BUSY=1. Raising EN issues on the next edge. Asserting RST one cycle after the issue edge -> no OUT_R pulse, and all outputs return to reset values.
- OP_LAT=3 build: two back-to-back issues (ch1 then ch2) -> OUT_R[1] and OUT_R[2] on consecutive cycles 5 and 6 cycles after capture, with OUT_D matching each channel's operands.

Source files
------------

// File: rtl/dataflow_op_arbiter.sv
// Round-robin arbiter sharing one registered two-operand pulse operator among CH channels.
// Define DFARB_ERR_EN to enable sticky per-channel overflow flags on ERR.
module dataflow_op_arbiter #(
  parameter int unsigned N      = 16,
  parameter int unsigned CH     = 4,
  parameter int unsigned OP_LAT = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic [CH-1:0]         IN_R1,
  input  logic [CH*N-1:0]       IN_D1,
  input  logic [CH-1:0]         IN_R2,
  input  logic [CH*N-1:0]       IN_D2,
  output logic                  OP_EN,
  output logic                  OP_R_IN1,
  output logic                  OP_R_IN2,
  output logic [N-1:0]          OP_D_IN1,
  output logic [N-1:0]          OP_D_IN2,
  input  logic                  OP_R_OUT,
  input  logic [N-1:0]          OP_D_OUT,
  output logic [CH-1:0]         OUT_R,
  output logic [N-1:0]          OUT_D,
  output logic [$clog2(CH)-1:0] OUT_CH,
  output logic                  BUSY,
  output logic [CH-1:0]         ERR,
  input  logic                  ERR_CLR
);
  localparam int unsigned   CW      = $clog2(CH);
  localparam logic [CW-1:0] LAST_CH = CW'(CH - 1);

  logic [N-1:0]      a_d [CH];
  logic [N-1:0]      b_d [CH];
  logic [CH-1:0]     a_f, b_f;
  logic [CW-1:0]     ptr;
  logic [CW-1:0]     iss_ch;
  logic [OP_LAT-1:0] tag_v;
  logic [CW-1:0]     tag_c [OP_LAT];

  logic              grant_vld_c;
  logic [CW-1:0]     grant_c;
  logic [CW-1:0]     ptr_nxt_c;
  logic [CH-1:0]     iss_c, ld_a_c, ld_b_c, ovf_c, a_f_nxt_c, b_f_nxt_c;
  logic [OP_LAT-1:0] tag_v_nxt_c;
  logic              res_vld_c;
  logic [CW-1:0]     res_ch_c;
  logic              busy_nxt_c;

  // Round-robin search over eligible channels, starting at ptr
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_vld_c = 1'b0;
    grant_c     = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      idx = (32'(ptr) + i) % CH;
      if (EN && !grant_vld_c && a_f[CW'(idx)] && b_f[CW'(idx)]) begin
        grant_vld_c = 1'b1;
        grant_c     = CW'(idx);
      end
    end
    iss_c     = grant_vld_c ? (CH'(1) << grant_c) : '0;
    ptr_nxt_c = (grant_c == LAST_CH) ? '0 : grant_c + CW'(1);
  end

  // Slot occupancy: a slot freed by this edge's issue may capture a new token
  always_comb begin
    ld_a_c     = IN_R1 & (~a_f | iss_c);
    ld_b_c     = IN_R2 & (~b_f | iss_c);
    ovf_c      = (IN_R1 & a_f & ~iss_c) | (IN_R2 & b_f & ~iss_c);
    a_f_nxt_c  = (a_f & ~iss_c) | ld_a_c;
    b_f_nxt_c  = (b_f & ~iss_c) | ld_b_c;
  end

  // Tag pipeline advances from the cycle the operator samples the issue
  always_comb begin
    tag_v_nxt_c    = '0;
    tag_v_nxt_c[0] = OP_R_IN1;
    for (int i = 1; i < int'(OP_LAT); i++) tag_v_nxt_c[i] = tag_v[i-1];
    res_vld_c  = OP_R_OUT & tag_v[OP_LAT-1];
    res_ch_c   = tag_c[OP_LAT-1];
    busy_nxt_c = (|a_f_nxt_c) | (|b_f_nxt_c) | grant_vld_c | (|tag_v_nxt_c);
  end

  // Operand and tag-channel storage (no reset needed; guarded by full/valid flags)
  always_ff @(posedge CLK) begin
    for (int k = 0; k < int'(CH); k++) begin
      if (ld_a_c[k]) a_d[k] <= IN_D1[k*N +: N];
      if (ld_b_c[k]) b_d[k] <= IN_D2[k*N +: N];
    end
    tag_c[0] <= iss_ch;
    for (int i = 1; i < int'(OP_LAT); i++) tag_c[i] <= tag_c[i-1];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_f      <= '0;
      b_f      <= '0;
      ptr      <= '0;
      iss_ch   <= '0;
      tag_v    <= '0;
      OP_EN    <= 1'b0;
      OP_R_IN1 <= 1'b0;
      OP_R_IN2 <= 1'b0;
      OP_D_IN1 <= '0;
      OP_D_IN2 <= '0;
      OUT_R    <= '0;
      OUT_D    <= '0;
      OUT_CH   <= '0;
      BUSY     <= 1'b0;
    end else begin
      a_f      <= a_f_nxt_c;
      b_f      <= b_f_nxt_c;
      tag_v    <= tag_v_nxt_c;
      OP_EN    <= 1'b1;
      OP_R_IN1 <= grant_vld_c;
      OP_R_IN2 <= grant_vld_c;
      if (grant_vld_c) begin
        OP_D_IN1 <= a_d[grant_c];
        OP_D_IN2 <= b_d[grant_c];
        iss_ch   <= grant_c;
        ptr      <= ptr_nxt_c;
      end
      OUT_R <= res_vld_c ? (CH'(1) << res_ch_c) : '0;
      if (res_vld_c) begin
        OUT_D  <= OP_D_OUT;
        OUT_CH <= res_ch_c;
      end
      BUSY <= busy_nxt_c;
    end
  end

`ifdef DFARB_ERR_EN
  // Sticky overflow flags; clear wins over a same-edge overflow
  always_ff @(posedge CLK) begin
    if (RST || ERR_CLR) ERR <= '0;
    else                ERR <= ERR | ovf_c;
  end
`else
  logic unused_err_c;
  assign unused_err_c = ^{ERR_CLR, ovf_c};
  assign ERR = '0;
`endif

endmodule
